branch_predictor: RTL and testbench

- Fetch-stage dynamic branch predictor. It is the consumer end of the decode-stage branch resolution: decode produces taken/target, and this block learns from it.
- Direct-mapped table; each entry holds a valid bit, a tag, a 2-bit saturating counter and a 16-bit target (BTB).
- Fetch gets a combinational prediction for the current PC. Decode writes the resolved outcome back synchronously.

---
 rtl/branch_predictor_if.sv | 25 ++
 rtl/branch_predictor.sv | 90 +++++++++
 tb/tb_branch_predictor.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/branch_predictor_if.sv
// Fetch/decode side bundle for the branch predictor: lookup port plus
// the resolved-branch write-back port.
`timescale 1ns/1ps
interface branch_predictor_if;
  logic        enable;
  logic [15:0] PC_curr;
  logic        predicted_taken;
  logic [15:0] predicted_target;
  logic        update_en;
  logic [15:0] update_PC;
  logic        actual_taken;
  logic [15:0] actual_target;

  // Pipeline side: drives lookups and resolved outcomes
  modport master (
    output enable, PC_curr, update_en, update_PC, actual_taken, actual_target,
    input  predicted_taken, predicted_target
  );

  // Predictor side
  modport slave (
    input  enable, PC_curr, update_en, update_PC, actual_taken, actual_target,
    output predicted_taken, predicted_target
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped dynamic branch predictor with 2-bit counters and a BTB.
// Lookup is combinational; resolved outcomes are written on the clock.
// Optional: define BP_WRITE_BYPASS_EN to forward a same-cycle write to
// a lookup on the same index.
`timescale 1ns/1ps
module branch_predictor #(
  parameter int unsigned IDX_W = 3
) (
  input logic               clk,
  input logic               rst_n,
  branch_predictor_if.slave bp
);
  localparam int unsigned TAG_W   = 15 - IDX_W;
  localparam int unsigned ENTRIES = 1 << IDX_W;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [1:0]       ctr;
    logic [15:0]      tgt;
  } entry_t;

  entry_t           tbl_q [ENTRIES];
  entry_t           upd_old;
  entry_t           upd_d;
  entry_t           rd_entry;
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_hit;
  logic             upd_we;
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;
  logic             unused_pc_lsb;

  // Halfword-aligned PCs: bit 0 never participates
  assign unused_pc_lsb = ^{bp.PC_curr[0], bp.update_PC[0]};

  // Next value of the entry addressed by the resolved branch
  always_comb begin
    upd_idx = bp.update_PC[IDX_W:1];
    upd_tag = bp.update_PC[15:IDX_W+1];
    upd_old = tbl_q[upd_idx];
    upd_hit = upd_old.valid && (upd_old.tag == upd_tag);
    upd_d   = upd_old;
    upd_we  = 1'b0;
    if (bp.update_en && bp.enable) begin
      if (upd_hit) begin
        upd_we = 1'b1;
        if (bp.actual_taken) begin
          if (upd_old.ctr != 2'b11) upd_d.ctr = upd_old.ctr + 2'd1;
          upd_d.tgt = bp.actual_target;
        end else begin
          if (upd_old.ctr != 2'b00) upd_d.ctr = upd_old.ctr - 2'd1;
        end
      end else if (bp.actual_taken) begin
        // Allocate, replacing whatever alias occupied the slot
        upd_we      = 1'b1;
        upd_d.valid = 1'b1;
        upd_d.tag   = upd_tag;
        upd_d.ctr   = 2'b10;
        upd_d.tgt   = bp.actual_target;
      end
    end
  end

  // Table storage; reset to invalid, weakly-not-taken, zero tag/target
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        tbl_q[i] <= '{valid: 1'b0, tag: '0, ctr: 2'b01, tgt: 16'h0000};
      end
    end else if (upd_we) begin
      tbl_q[upd_idx] <= upd_d;
    end
  end

  // Zero-latency prediction for the fetch PC
  always_comb begin
    lk_idx   = bp.PC_curr[IDX_W:1];
    lk_tag   = bp.PC_curr[15:IDX_W+1];
    rd_entry = tbl_q[lk_idx];
`ifdef BP_WRITE_BYPASS_EN
    if (bp.update_en && bp.enable && (upd_idx == lk_idx)) rd_entry = upd_d;
`endif
    lk_hit               = rd_entry.valid && (rd_entry.tag == lk_tag);
    bp.predicted_taken   = lk_hit && rd_entry.ctr[1];
    bp.predicted_target  = lk_hit ? rd_entry.tgt : 16'h0000;
  end
endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: directed scenarios followed by
// random traffic, checked against an array-based reference model.
`timescale 1ns/1ps
module tb_branch_predictor;
  localparam int IDX_W   = 3;
  localparam int ENTRIES = 1 << IDX_W;

  logic clk;
  logic rst_n;
  branch_predictor_if bp_if ();

  branch_predictor #(.IDX_W(IDX_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bp    (bp_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  bit m_valid [ENTRIES];
  int m_tag   [ENTRIES];
  int m_ctr   [ENTRIES];
  int m_tgt   [ENTRIES];

  // Scoreboard queues
  bit          exp_tk_q  [$];
  logic [15:0] exp_tgt_q [$];
  string       exp_nm_q  [$];

  int n_checks;
  int n_fails;

  task automatic m_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = 0;
      m_ctr[i]   = 1;
      m_tgt[i]   = 0;
    end
  endtask

  task automatic m_update(input logic [15:0] pc, input bit tk, input logic [15:0] tg);
    int i;
    int t;
    i = (int'(pc) / 2) % ENTRIES;
    t = int'(pc) / (2 * ENTRIES);
    if (m_valid[i] && m_tag[i] == t) begin
      if (tk) begin
        m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
        m_tgt[i] = int'(tg);
      end else begin
        m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
      end
    end else if (tk) begin
      m_valid[i] = 1'b1;
      m_tag[i]   = t;
      m_ctr[i]   = 2;
      m_tgt[i]   = int'(tg);
    end
  endtask

  task automatic m_lookup(input logic [15:0] pc, output bit tk, output logic [15:0] tg);
    int i;
    bit hit;
    i   = (int'(pc) / 2) % ENTRIES;
    hit = m_valid[i] && (m_tag[i] == int'(pc) / (2 * ENTRIES));
    tk  = hit && (m_ctr[i] >= 2);
    tg  = hit ? 16'(m_tgt[i]) : 16'h0000;
  endtask

  // One cycle of stimulus, driven just after the rising edge
  task automatic cycle(input bit rst, input bit en, input logic [15:0] pc,
                       input bit upd, input logic [15:0] upc, input bit tk,
                       input logic [15:0] tg, input string nm);
    bit          e_tk;
    logic [15:0] e_tg;
    bit          do_upd;
    @(posedge clk);
    #1;
    rst_n                = rst;
    bp_if.enable         = en;
    bp_if.PC_curr        = pc;
    bp_if.update_en      = upd;
    bp_if.update_PC      = upc;
    bp_if.actual_taken   = tk;
    bp_if.actual_target  = tg;
    if (!rst) m_reset();
    do_upd = rst && en && upd;
`ifdef BP_WRITE_BYPASS_EN
    if (do_upd && (((int'(pc) / 2) % ENTRIES) == ((int'(upc) / 2) % ENTRIES))) begin
      m_update(upc, tk, tg);
      do_upd = 1'b0;
    end
`endif
    m_lookup(pc, e_tk, e_tg);
    exp_tk_q.push_back(e_tk);
    exp_tgt_q.push_back(e_tg);
    exp_nm_q.push_back(nm);
    if (do_upd) m_update(upc, tk, tg);
  endtask

  task automatic look(input logic [15:0] pc, input string nm);
    cycle(1'b1, 1'b1, pc, 1'b0, 16'h0000, 1'b0, 16'h0000, nm);
  endtask

  task automatic upd_look(input logic [15:0] upc, input bit tk, input logic [15:0] tg,
                          input logic [15:0] pc, input string nm);
    cycle(1'b1, 1'b1, pc, 1'b1, upc, tk, tg, nm);
  endtask

  // Monitor: compare DUT outputs mid-cycle against queued expectations
  always @(negedge clk) begin
    if (exp_tk_q.size() > 0) begin
      bit          e_tk;
      logic [15:0] e_tg;
      string       nm;
      e_tk = exp_tk_q.pop_front();
      e_tg = exp_tgt_q.pop_front();
      nm   = exp_nm_q.pop_front();
      n_checks++;
      if (bp_if.predicted_taken !== e_tk) begin
        n_fails++;
        $display("FAIL %s taken: got %0b want %0b (t=%0t)", nm, bp_if.predicted_taken, e_tk, $time);
      end
      n_checks++;
      if (bp_if.predicted_target !== e_tg) begin
        n_fails++;
        $display("FAIL %s target: got %h want %h (t=%0t)", nm, bp_if.predicted_target, e_tg, $time);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_fails  = 0;
    m_reset();
    rst_n               = 1'b0;
    bp_if.enable        = 1'b0;
    bp_if.PC_curr       = 16'h0000;
    bp_if.update_en     = 1'b0;
    bp_if.update_PC     = 16'h0000;
    bp_if.actual_taken  = 1'b0;
    bp_if.actual_target = 16'h0000;

    // Reset and clean lookups of every slot
    cycle(1'b0, 1'b1, 16'h0000, 1'b1, 16'h0000, 1'b1, 16'h1234, "reset_hold");
    cycle(1'b0, 1'b1, 16'h0002, 1'b0, 16'h0000, 1'b0, 16'h0000, "reset_hold2");
    for (int i = 0; i < ENTRIES; i++) look(16'(2 * i), "post_reset");

    // Allocate on taken; no bypass means the write is visible next cycle
    upd_look(16'h0010, 1'b1, 16'h0040, 16'h0010, "alloc_same_cycle");
    look(16'h0010, "alloc_hit");

    // Counter hysteresis
    upd_look(16'h0010, 1'b0, 16'h0000, 16'h0010, "hyst_nt1");
    upd_look(16'h0010, 1'b0, 16'h0000, 16'h0010, "hyst_nt2");
    upd_look(16'h0010, 1'b0, 16'h0000, 16'h0010, "hyst_nt_sat");
    upd_look(16'h0010, 1'b1, 16'h0044, 16'h0010, "hyst_t1");
    upd_look(16'h0010, 1'b1, 16'h0048, 16'h0010, "hyst_t2");
    upd_look(16'h0010, 1'b1, 16'h004C, 16'h0010, "hyst_t3");
    upd_look(16'h0010, 1'b1, 16'h0050, 16'h0010, "hyst_t4");
    upd_look(16'h0010, 1'b0, 16'h0000, 16'h0010, "hyst_nt_after_sat");
    look(16'h0010, "hyst_final");

    // Aliasing on index 0
    look(16'h0030, "alias_miss");
    upd_look(16'h0030, 1'b1, 16'h0100, 16'h0010, "alias_write");
    look(16'h0030, "alias_new_hit");
    look(16'h0010, "alias_old_miss");

    // Not-taken miss and stalled update leave state alone
    upd_look(16'h0022, 1'b0, 16'h0000, 16'h0022, "nt_miss_write");
    look(16'h0022, "nt_miss_look");
    cycle(1'b1, 1'b0, 16'h0022, 1'b1, 16'h0022, 1'b1, 16'h0200, "stall_write");
    look(16'h0022, "stall_look");

    // Mid-operation reset with update held
    upd_look(16'h0010, 1'b1, 16'h0040, 16'h0030, "realloc");
    look(16'h0010, "realloc_hit");
    cycle(1'b0, 1'b1, 16'h0010, 1'b1, 16'h0010, 1'b1, 16'h0077, "mid_reset");
    cycle(1'b0, 1'b1, 16'h0010, 1'b1, 16'h0012, 1'b1, 16'h0078, "mid_reset_hold");
    look(16'h0010, "after_reset_0010");
    look(16'h0012, "after_reset_0012");

    // Random traffic over a small PC space so hits and aliases are common
    for (int n = 0; n < 400; n++) begin
      logic [15:0] pc;
      logic [15:0] upc;
      pc  = 16'($urandom) & 16'h007F;
      upc = 16'($urandom) & 16'h007F;
      if ($urandom_range(0, 3) == 0) upc = pc;
      cycle(1'b1, ($urandom_range(0, 9) != 0), pc, 1'($urandom_range(0, 1)), upc,
            1'($urandom_range(0, 1)), 16'($urandom), "random");
    end

    @(negedge clk);
    #1;
    n_checks++;
    if (exp_tk_q.size() != 0) begin
      n_fails++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", exp_tk_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
